// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared constants and helpers for the local-history branch predictor.
//   - Default table geometry (BHT index width, history length, PHT index width)
//   - Default saturating-counter width and the widest counter supported
//   - sat_next(): next value of a saturating up/down counter of width ctr_w
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_BHT_IDX_W = 10;
    localparam int BP_HIST_W    = 6;
    localparam int BP_PHT_IDX_W = 6;
    localparam int BP_CTR_W     = 2;
    localparam int BP_CTR_W_MAX = 4;

    // Counters of any legal width are carried in a BP_CTR_W_MAX-wide container;
    // ctr_w sets the saturation ceiling so narrow counters never wrap.
    function automatic logic [BP_CTR_W_MAX-1:0] sat_next(
        input logic [BP_CTR_W_MAX-1:0] cur,
        input logic                    taken,
        input int                      ctr_w
    );
        logic [BP_CTR_W_MAX-1:0] top;
        top = BP_CTR_W_MAX'((32'd1 << ctr_w) - 32'd1);
        if (taken) begin
            return (cur >= top) ? cur : cur + BP_CTR_W_MAX'(1);
        end
        return (cur == '0) ? cur : cur - BP_CTR_W_MAX'(1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// -----------------------------------------------------------------------------
// bp_sat_ctr
// Combinational next-state for one CTR_W-bit saturating direction counter.
// Ports:
//   cur   - current counter value
//   taken - resolved branch direction (1 = taken, count up)
//   nxt   - next counter value, clamped to [0, 2**CTR_W-1]
// -----------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = BP_CTR_W
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = CTR_W'(sat_next(BP_CTR_W_MAX'(cur), taken, CTR_W));
    end

endmodule

// File: rtl/branch_predict_local_param.sv
// -----------------------------------------------------------------------------
// branch_predict_local_param
// Two-level local-history branch direction predictor for a 5-stage pipeline.
// A per-PC history table (BHT) selects, XORed with PC bits, a saturating
// counter in the pattern history table (PHT). Prediction is read in F,
// carried through D and E, and checked against the resolved direction in E.
// Tables are trained from the M stage.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   flushD/stallD            - D pipeline register control
//   flushE/stallE            - E pipeline register control
//   pcF, pcM                 - fetch PC (lookup) and memory-stage PC (update)
//   branchD/E/M              - stage holds a conditional branch
//   actual_takeE/M           - resolved direction in E / M
//   pred_takeD               - predicted taken for the branch in D
//   pred_resM                - misprediction flag for the branch now in M
//   br_cnt, mis_cnt          - retired-branch and misprediction counters
// -----------------------------------------------------------------------------
module branch_predict_local_param
    import bp_pkg::*;
#(
    parameter int BHT_IDX_W = BP_BHT_IDX_W,
    parameter int HIST_W    = BP_HIST_W,
    parameter int PHT_IDX_W = BP_PHT_IDX_W,
    parameter int CTR_W     = BP_CTR_W,
    parameter int CTR_INIT  = 2**(CTR_W-1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushD,
    input  logic        stallD,
    input  logic        flushE,
    input  logic        stallE,
    input  logic [31:0] pcF,
    input  logic [31:0] pcM,
    input  logic        branchD,
    input  logic        branchE,
    input  logic        branchM,
    input  logic        actual_takeE,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        pred_resM,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam int BHT_DEPTH = 2**BHT_IDX_W;
    localparam int PHT_DEPTH = 2**PHT_IDX_W;

    logic [HIST_W-1:0]    bht [BHT_DEPTH];
    logic [CTR_W-1:0]     pht [PHT_DEPTH];

    logic [BHT_IDX_W-1:0] bht_idx_f;
    logic [BHT_IDX_W-1:0] bht_idx_m;
    logic [HIST_W-1:0]    hist_f;
    logic [HIST_W-1:0]    hist_m;
    logic [HIST_W-1:0]    hist_m_nxt;
    logic [PHT_IDX_W-1:0] pht_idx_f;
    logic [PHT_IDX_W-1:0] pht_idx_m;
    logic [CTR_W-1:0]     ctr_m;
    logic [CTR_W-1:0]     ctr_m_nxt;
    logic                 pred_f;
    logic                 pred_d;
    logic                 pred_e;
    logic                 pred_res;
    logic                 unused_pc_bits;

    // Fetch-side lookup. History is zero-extended before the XOR when it is
    // shorter than the PHT index. A same-cycle M write is not forwarded, so
    // F always sees the table contents from before this edge.
    assign bht_idx_f = pcF[BHT_IDX_W+1:2];
    assign hist_f    = bht[bht_idx_f];
    assign pht_idx_f = PHT_IDX_W'(hist_f) ^ pcF[PHT_IDX_W+1:2];
    assign pred_f    = pht[pht_idx_f][CTR_W-1];

    // Update-side lookup uses the history as it was before this branch's
    // outcome is shifted in, matching the index the prediction came from.
    assign bht_idx_m  = pcM[BHT_IDX_W+1:2];
    assign hist_m     = bht[bht_idx_m];
    assign pht_idx_m  = PHT_IDX_W'(hist_m) ^ pcM[PHT_IDX_W+1:2];
    assign ctr_m      = pht[pht_idx_m];
    assign hist_m_nxt = HIST_W'({hist_m, actual_takeM});

    // PC bits outside the index fields play no part in prediction.
    assign unused_pc_bits = ^{pcF, pcM};

    bp_sat_ctr #(
        .CTR_W (CTR_W)
    ) u_sat_ctr (
        .cur   (ctr_m),
        .taken (actual_takeM),
        .nxt   (ctr_m_nxt)
    );

    // Table storage. Only a branch in M trains; reset wipes every entry
    // immediately, so a branch caught in M during reset never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= '0;
            end
            for (int j = 0; j < PHT_DEPTH; j++) begin
                pht[j] <= CTR_W'(CTR_INIT);
            end
        end else if (branchM) begin
            bht[bht_idx_m] <= hist_m_nxt;
            pht[pht_idx_m] <= ctr_m_nxt;
        end
    end

    // Prediction pipeline. E carries the gated prediction that was actually
    // presented in D, so the misprediction check never re-reads the tables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_d   <= 1'b0;
            pred_e   <= 1'b0;
            pred_res <= 1'b0;
        end else begin
            if (flushD) begin
                pred_d <= 1'b0;
            end else if (!stallD) begin
                pred_d <= pred_f;
            end

            if (flushE) begin
                pred_e <= 1'b0;
            end else if (!stallE) begin
                pred_e <= pred_takeD;
            end

            if (flushE) begin
                pred_res <= 1'b0;
            end else begin
                pred_res <= branchE & (pred_e != actual_takeE);
            end
        end
    end

    assign pred_takeD = branchD & pred_d;
    assign pred_resM  = pred_res;

    // Statistics counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (branchM) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (pred_resM) begin
                mis_cnt <= mis_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_local_param.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_local_param
// Directed and randomized bench for branch_predict_local_param at default
// parameters. Expected outputs come from an array-based reference model of
// the predictor's rules kept in this file.
// -----------------------------------------------------------------------------
module tb_branch_predict_local_param;

    localparam int BHT_N    = 2**10;
    localparam int HIST_N   = 2**6;
    localparam int PHT_N    = 2**6;
    localparam int CTR_MAX  = 2**2 - 1;
    localparam int CTR_HALF = 2**(2-1);
    localparam int CTR_RST  = 2**(2-1);

    logic        clk = 1'b0;
    logic        rst;
    logic        flushD, stallD, flushE, stallE;
    logic [31:0] pcF, pcM;
    logic        branchD, branchE, branchM;
    logic        actual_takeE, actual_takeM;
    logic        pred_takeD, pred_resM;
    logic [31:0] br_cnt, mis_cnt;

    int compared   = 0;
    int mismatched = 0;

    int          bht_m [BHT_N];
    int          pht_m [PHT_N];
    bit          m_predD, m_predE, m_resM;
    logic [31:0] m_br, m_mis;

    logic [31:0] pc_pool [8] = '{32'h100, 32'h104, 32'h108, 32'h200,
                                 32'h300, 32'h1100, 32'h40C, 32'h7FC};

    branch_predict_local_param dut (
        .clk          (clk),
        .rst          (rst),
        .flushD       (flushD),
        .stallD       (stallD),
        .flushE       (flushE),
        .stallE       (stallE),
        .pcF          (pcF),
        .pcM          (pcM),
        .branchD      (branchD),
        .branchE      (branchE),
        .branchM      (branchM),
        .actual_takeE (actual_takeE),
        .actual_takeM (actual_takeM),
        .pred_takeD   (pred_takeD),
        .pred_resM    (pred_resM),
        .br_cnt       (br_cnt),
        .mis_cnt      (mis_cnt)
    );

    always #5 clk = ~clk;

    // Model table addressing: word-address modulo table size, history
    // folded into the pattern index by XOR.
    function automatic int bhtSlot(input logic [31:0] pc);
        return int'((pc / 4) % BHT_N);
    endfunction

    function automatic int phtSlot(input logic [31:0] pc);
        return (bht_m[bhtSlot(pc)] ^ int'((pc / 4) % PHT_N)) % PHT_N;
    endfunction

    // Everything the model tracks returns to its power-on state.
    task automatic modelReset();
        for (int i = 0; i < BHT_N; i++) bht_m[i] = 0;
        for (int i = 0; i < PHT_N; i++) pht_m[i] = CTR_RST;
        m_predD = 1'b0;
        m_predE = 1'b0;
        m_resM  = 1'b0;
        m_br    = '0;
        m_mis   = '0;
    endtask

    // Quiet pipeline: nothing in flight, no flush or stall.
    task automatic idle();
        flushD = 0; stallD = 0; flushE = 0; stallE = 0;
        pcF = '0; pcM = '0;
        branchD = 0; branchE = 0; branchM = 0;
        actual_takeE = 0; actual_takeM = 0;
    endtask

    task automatic expectBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic expectWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Let the freshly driven inputs settle, then compare every output to the model.
    task automatic checkOutput(input string tag);
        #1;
        expectBit({tag, ".pred_takeD"}, pred_takeD, branchD && m_predD);
        expectBit({tag, ".pred_resM"}, pred_resM, m_resM);
        expectWord({tag, ".br_cnt"}, br_cnt, m_br);
        expectWord({tag, ".mis_cnt"}, mis_cnt, m_mis);
    endtask

    // Advance one clock with the current inputs, stepping the model alongside.
    task automatic applyStimulus();
        bit          f_pred, n_predD, n_predE, n_resM;
        logic [31:0] n_br, n_mis;
        int          ui, ux, n_hist, n_ctr;
        f_pred  = pht_m[phtSlot(pcF)] >= CTR_HALF;
        n_predD = flushD ? 1'b0 : (stallD ? m_predD : f_pred);
        n_predE = flushE ? 1'b0 : (stallE ? m_predE : (branchD && m_predD));
        n_resM  = flushE ? 1'b0 : (branchE && (m_predE != actual_takeE));
        n_br    = m_br + (branchM ? 32'd1 : 32'd0);
        n_mis   = m_mis + (m_resM ? 32'd1 : 32'd0);
        ui = bhtSlot(pcM);
        ux = phtSlot(pcM);
        n_hist = (bht_m[ui] * 2 + (actual_takeM ? 1 : 0)) % HIST_N;
        n_ctr  = actual_takeM ? ((pht_m[ux] + 1 > CTR_MAX) ? CTR_MAX : pht_m[ux] + 1)
                              : ((pht_m[ux] - 1 < 0) ? 0 : pht_m[ux] - 1);
        @(posedge clk);
        if (branchM) begin
            bht_m[ui] = n_hist;
            pht_m[ux] = n_ctr;
        end
        m_predD = n_predD;
        m_predE = n_predE;
        m_resM  = n_resM;
        m_br    = n_br;
        m_mis   = n_mis;
        @(negedge clk);
    endtask

    // Random traffic over a small PC pool so histories and counters alias.
    task automatic runRandom(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            flushD       = ($urandom_range(0, 15) == 0);
            stallD       = ($urandom_range(0, 7) == 0);
            flushE       = ($urandom_range(0, 15) == 0);
            stallE       = ($urandom_range(0, 7) == 0);
            pcF          = pc_pool[$urandom_range(0, 7)];
            pcM          = pc_pool[$urandom_range(0, 7)];
            branchD      = $urandom_range(0, 1) == 1;
            branchE      = $urandom_range(0, 1) == 1;
            branchM      = $urandom_range(0, 2) != 0;
            actual_takeE = $urandom_range(0, 1) == 1;
            actual_takeM = $urandom_range(0, 1) == 1;
            checkOutput(tag);
            applyStimulus();
        end
    endtask

    initial begin
        bit loop_act [$];
        int k;

        // Power-on reset.
        rst = 1'b0;
        idle();
        modelReset();
        @(negedge clk);
        checkOutput("reset");
        rst = 1'b1;
        applyStimulus();

        // Fresh tables predict weakly taken; nothing retired yet.
        pcF = 32'h100;
        checkOutput("fresh_load");
        applyStimulus();
        branchD = 1;
        checkOutput("fresh_pred");
        expectBit("fresh_pred_taken", pred_takeD, 1'b1);
        expectWord("fresh_br_cnt", br_cnt, 32'd0);
        applyStimulus();

        // Three not-taken trainings saturate the counter at zero.
        idle();
        pcM = 32'h200; branchM = 1; actual_takeM = 0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sat_train");
            applyStimulus();
        end
        idle();
        pcF = 32'h200;
        checkOutput("sat_load");
        applyStimulus();
        branchD = 1;
        checkOutput("sat_pred");
        expectBit("sat_pred_nt", pred_takeD, 1'b0);
        expectWord("sat_br_cnt", br_cnt, 32'd3);
        applyStimulus();

        // Taken prediction resolved not-taken: flag one cycle after E.
        idle(); pcF = 32'h104;
        checkOutput("mis_load"); applyStimulus();
        branchD = 1;
        checkOutput("mis_d"); expectBit("mis_d_taken", pred_takeD, 1'b1); applyStimulus();
        idle(); branchE = 1; actual_takeE = 0;
        checkOutput("mis_e"); applyStimulus();
        idle();
        checkOutput("mis_m"); expectBit("mis_flag", pred_resM, 1'b1);
        expectWord("mis_cnt_before", mis_cnt, 32'd0); applyStimulus();
        checkOutput("mis_after"); expectWord("mis_cnt_after", mis_cnt, 32'd1);
        applyStimulus();

        // Same again, but a flushE alongside the E-stage resolution kills the flag.
        idle(); pcF = 32'h104;
        checkOutput("flush_load"); applyStimulus();
        branchD = 1;
        checkOutput("flush_d"); applyStimulus();
        idle(); branchE = 1; actual_takeE = 0; flushE = 1;
        checkOutput("flush_e"); applyStimulus();
        idle();
        checkOutput("flush_m"); expectBit("flush_flag", pred_resM, 1'b0); applyStimulus();
        checkOutput("flush_after"); expectWord("flush_mis_cnt", mis_cnt, 32'd1);
        applyStimulus();

        // stallD holds the D prediction while fetch wanders.
        idle(); pcF = 32'h104;
        checkOutput("stall_load"); applyStimulus();
        branchD = 1; stallD = 1;
        for (int i = 0; i < 3; i++) begin
            pcF = (i == 0) ? 32'h200 : ((i == 1) ? 32'h0 : 32'h300);
            checkOutput("stall_hold");
            expectBit("stall_hold_pred", pred_takeD, 1'b1);
            applyStimulus();
        end
        stallD = 0; pcF = 32'h200;
        checkOutput("stall_release");
        expectBit("stall_release_pred", pred_takeD, 1'b1);
        applyStimulus();

        // Loop branch T,T,T,N learned by local history; after warm-up each
        // prediction (visible a cycle later) matches the outcome it served.
        idle();
        pcF = 32'h300; pcM = 32'h300; branchD = 1; branchM = 1;
        k = 0;
        for (int i = 0; i < 80; i++) begin
            actual_takeM = (k % 4) != 3;
            checkOutput("loop");
            if (i >= 40) expectBit("loop_pred", pred_takeD, loop_act[$]);
            loop_act.push_back(actual_takeM);
            applyStimulus();
            k++;
        end
        // Bubbles with no branch in M must leave the learned pattern intact.
        branchM = 0;
        for (int i = 0; i < 6; i++) begin
            pcM = pc_pool[$urandom_range(0, 7)];
            actual_takeM = $urandom_range(0, 1) == 1;
            checkOutput("loop_bubble");
            applyStimulus();
        end
        pcM = 32'h300; branchM = 1;
        for (int i = 0; i < 16; i++) begin
            actual_takeM = (k % 4) != 3;
            checkOutput("loop_resume");
            if (i >= 1) expectBit("loop_resume_pred", pred_takeD, loop_act[$]);
            loop_act.push_back(actual_takeM);
            applyStimulus();
            k++;
        end

        runRandom(400, "rand_a");

        // Reset mid-stream with a branch in M: immediate reset values, no update.
        idle();
        pcF = 32'h300; pcM = 32'h200; branchD = 1; branchM = 1; actual_takeM = 1;
        branchE = 1; actual_takeE = 1;
        rst = 1'b0;
        modelReset();
        checkOutput("mid_reset");
        expectBit("mid_reset_pred", pred_takeD, 1'b0);
        expectWord("mid_reset_br_cnt", br_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_reset");
        idle();
        rst = 1'b1;
        pcF = 32'h200;
        checkOutput("post_reset_load"); applyStimulus();
        branchD = 1;
        checkOutput("post_reset_pred");
        expectBit("post_reset_pred_taken", pred_takeD, 1'b1);
        applyStimulus();

        runRandom(200, "rand_b");

        $display("[TB] run complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
